// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction/byte widths, the instruction field layout
// used by the executor's decoder, and the framer's byte-pairing states.
package isa_pkg;

  localparam int INST_W = 16;
  localparam int BYTE_W = 8;

  // Field layout: [Op 15:14][Mod 13:8][Src 7:4][Dst 3:0]
  typedef struct packed {
    logic [1:0] op;
    logic [5:0] mod;
    logic [3:0] src;
    logic [3:0] dst;
  } inst_t;

  typedef enum logic {
    EMPTY_HALF = 1'b0,
    HAVE_HIGH  = 1'b1
  } frame_state_t;

  function automatic inst_t pack_inst(input logic [BYTE_W-1:0] hi,
                                      input logic [BYTE_W-1:0] lo);
    return inst_t'({hi, lo});
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is visible on rd_data
// combinationally; rd_en pops it. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_do;
  logic             rd_do;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  assign wr_do   = wr_en & ~full;
  assign rd_do   = rd_en & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_do) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_do) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_do, rd_do})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do && !clr && !rst) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/uart_inst_framer.sv
// Pairs UART bytes into 16-bit instructions {high, low}, buffers them in a FWFT
// FIFO, and drops a stranded high byte after an inter-byte timeout.
module uart_inst_framer
  import isa_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             byte_data,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [INST_W-1:0]             inst_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          timeout_drop
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  frame_state_t        state_reg;
  logic [BYTE_W-1:0]   hi_byte_reg;
  logic [TW-1:0]       timer_reg;
  logic                timeout_drop_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic [INST_W-1:0]   fifo_rd_data;
  inst_t               wr_inst;
  logic                byte_fire;
  logic                fifo_wr;
  logic                fifo_rd;

  // Only a low byte can be refused, and only while there is nowhere to put it.
  assign byte_ready   = ~((state_reg == HAVE_HIGH) & fifo_full);
  assign byte_fire    = byte_valid & byte_ready;
  assign fifo_wr      = byte_fire & (state_reg == HAVE_HIGH) & ~flush;
  assign fifo_rd      = inst_ready & ~fifo_empty;
  assign wr_inst      = pack_inst(hi_byte_reg, byte_data);
  assign inst_valid   = ~fifo_empty;
  assign inst_data    = fifo_empty ? '0 : fifo_rd_data;
  assign timeout_drop = timeout_drop_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg        <= EMPTY_HALF;
      hi_byte_reg      <= '0;
      timer_reg        <= '0;
      timeout_drop_reg <= 1'b0;
    end else begin
      timeout_drop_reg <= 1'b0;
      case (state_reg)
        EMPTY_HALF: begin
          if (byte_fire) begin
            hi_byte_reg <= byte_data;
            timer_reg   <= '0;
            state_reg   <= HAVE_HIGH;
          end
        end
        HAVE_HIGH: begin
          if (byte_fire) begin
            timer_reg <= '0;
            state_reg <= EMPTY_HALF;
          end else if (!fifo_full) begin
            // Backpressure (full FIFO) freezes the timer: it is not a framing error.
            if (timer_reg == TIMER_LAST) begin
              timer_reg        <= '0;
              state_reg        <= EMPTY_HALF;
              timeout_drop_reg <= 1'b1;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
        end
        default: state_reg <= EMPTY_HALF;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (fifo_wr),
    .wr_data (wr_inst),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_uart_inst_framer.sv
// Scoreboard bench for uart_inst_framer: stimulus pushes expected instructions,
// a monitor pops and compares on every output handshake.
module tb_uart_inst_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] inst_data;
  logic        inst_valid;
  logic        inst_ready;
  logic        flush;
  logic [2:0]  level;
  logic        timeout_drop;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          drop_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  uart_inst_framer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .inst_data    (inst_data),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .flush        (flush),
    .level        (level),
    .timeout_drop (timeout_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every output handshake pops one expected instruction.
  always @(negedge clk) begin
    if (!rst && !flush && inst_valid && inst_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop: got %04h, expected nothing (scoreboard empty)", inst_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (inst_data !== e) begin
          n_fail++;
          $display("FAIL pop: got %04h, expected %04h", inst_data, e);
        end else begin
          $display("ok   pop: %04h", inst_data);
        end
      end
    end
    if (timeout_drop) drop_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (byte_ready) done = 1;
      tick();
    end
    byte_valid = 1'b0;
    if (!done) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic send_inst(input logic [15:0] v);
    exp_q.push_back(v);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  initial begin
    int d0;
    rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_data = '0; inst_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset byte_ready", byte_ready, 1);
    chk("reset inst_valid", inst_valid, 0);
    chk("reset inst_data", inst_data, 0);
    chk("reset level", level, 0);
    chk("reset timeout_drop", timeout_drop, 0);

    // Pairing with idle gaps
    exp_q.push_back(16'h4123);
    send_byte(8'h41); tick(); tick();
    send_byte(8'h23);
    chk("pair level1", level, 1);
    chk("pair head", inst_data, 16'h4123);
    send_inst(16'h0053);
    chk("pair level2", level, 2);
    pop(); chk("pair level after pop1", level, 1);
    pop(); chk("pair level after pop2", level, 0);

    // Full FIFO and low-byte backpressure
    send_inst(16'h0102); send_inst(16'h0304); send_inst(16'h0506); send_inst(16'h0708);
    chk("full level", level, 4);
    send_byte(8'h09);
    chk("full byte_ready after 9th", byte_ready, 0);
    exp_q.push_back(16'h090A);
    byte_data = 8'h0A; byte_valid = 1'b1;
    tick(); tick();
    chk("full 10th refused", byte_ready, 0);
    chk("full level held", level, 4);
    pop();
    chk("full ready after pop", byte_ready, 1);
    tick();
    byte_valid = 1'b0;
    chk("full level refilled", level, 4);
    repeat (4) pop();
    chk("full drained", level, 0);

    // Timeout drops a lone high byte 16 cycles after acceptance
    d0 = drop_cnt;
    send_byte(8'hAA);
    repeat (15) tick();
    chk("timeout not yet", timeout_drop, 0);
    tick();
    chk("timeout pulse", timeout_drop, 1);
    tick();
    chk("timeout pulse one cycle", timeout_drop, 0);
    chk("timeout pulse count", drop_cnt - d0, 1);
    send_inst(16'h1234);
    pop();

    // Low byte on the 16th cycle wins over the timeout
    d0 = drop_cnt;
    exp_q.push_back(16'hAA5C);
    send_byte(8'hAA);
    repeat (15) tick();
    send_byte(8'h5C);
    tick();
    chk("race no pulse", drop_cnt - d0, 0);
    chk("race level", level, 1);
    pop();

    // Timer pauses while full
    d0 = drop_cnt;
    send_inst(16'hA1A2); send_inst(16'hA3A4); send_inst(16'hA5A6); send_inst(16'hA7A8);
    exp_q.push_back(16'h7788);
    send_byte(8'h77);
    repeat (40) tick();
    chk("pause no pulse", drop_cnt - d0, 0);
    chk("pause still pending", byte_ready, 0);
    pop();
    send_byte(8'h88);
    chk("pause level", level, 4);
    repeat (4) pop();
    chk("pause drop count", drop_cnt - d0, 0);

    // Write and pop in the same cycle
    send_inst(16'hC1C2); send_inst(16'hC3C4);
    exp_q.push_back(16'hC5C6);
    send_byte(8'hC5);
    byte_data = 8'hC6; byte_valid = 1'b1; inst_ready = 1'b1;
    tick();
    byte_valid = 1'b0; inst_ready = 1'b0;
    chk("concurrent level", level, 2);
    chk("concurrent head", inst_data, 16'hC3C4);
    repeat (2) pop();

    // Flush with level 3 and a high byte pending
    d0 = drop_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'hEE);
    chk("preflush level", level, 3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush level", level, 0);
    chk("flush inst_valid", inst_valid, 0);
    chk("flush inst_data", inst_data, 0);
    tick();
    chk("flush no pulse", drop_cnt - d0, 0);
    send_inst(16'h5566);
    chk("flush fresh head", inst_data, 16'h5566);
    pop();

    // Reset mid-instruction behaves like flush
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'hEF);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst level", level, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_data", inst_data, 0);
    chk("rst byte_ready", byte_ready, 1);
    send_inst(16'h789A);
    chk("rst fresh head", inst_data, 16'h789A);
    pop();

    tick();
    chk("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_inst_framer.md
# uart_inst_framer

Front-end stage between the 100 MHz `uart_rx` byte stream and the ISA execution core. It pairs received bytes into 16-bit instructions: the first byte is [15:8] and the second byte is [7:0]. It buffers completed instructions in a small first-word-fall-through FIFO, so the executor can stall on SDRAM PUSH/POP without losing input. An inter-byte timeout discards a stranded high byte, so a lost byte cannot permanently misalign instruction framing.

## Interface
- `FIFO_DEPTH`, default 4: instruction entries; must be a power of 2 and ≥2.
- `TIMEOUT_CYCLES`, default 200000: cycles a lone high byte may wait for its low byte (2 ms @ 100 MHz, about 23 byte times at 115200).
- `clk  in  1`: single clock for all logic.
- `rst  in  1`: synchronous reset, active-high.
- `byte_data  in  8`: received byte.
- `byte_valid  in  1`: `byte_data` is valid.
- `byte_ready  out  1`: framer accepts the byte this cycle.
- `inst_data  out  16`: head instruction {high, low}.
- `inst_valid  out  1`: FIFO not empty.
- `inst_ready  in  1`: executor consumes the head this cycle.
- `flush  in  1`: discard all buffered and partial state.
- `level  out  $clog2(FIFO_DEPTH)+1`: number of stored instructions.
- `timeout_drop  out  1`: one-cycle pulse when a high byte is discarded by timeout.

## Operation
- **Handshakes.** A byte transfers on `byte_valid & byte_ready`. An instruction transfers on `inst_valid & inst_ready`.
- **State.** `hi_valid` flag, `hi_byte` register, timeout counter, FIFO storage, and FIFO pointers.
- **Byte acceptance.**
  - `byte_ready = ~(hi_valid & full)`, combinational from registered state only.
  - A high byte is always accepted.
  - A low byte is refused while the FIFO is full.
- **Framing states.**
  - EMPTY_HALF (`hi_valid`=0): an accepted byte goes to `hi_byte`; go to HAVE_HIGH and clear the counter.
  - HAVE_HIGH (`hi_valid`=1): an accepted byte writes {`hi_byte`, `byte_data`} to the FIFO tail; go to EMPTY_HALF.
  - HAVE_HIGH, timeout: when the counter reaches `TIMEOUT_CYCLES-1` with no low byte accepted that cycle, clear `hi_valid` and pulse `timeout_drop`.
- **Timeout counter.** Increments each cycle in HAVE_HIGH while `full`=0. It holds while `full`=1, because backpressure is not a framing error.
- **Simultaneous low byte and timeout.** The low byte wins: the instruction is written and there is no pulse.
- **Read and write in the same cycle.** `level` is unchanged. When full, no write can occur, since `byte_ready`=0 in HAVE_HIGH.
- **Output.**
  - `inst_data` is combinational from the head entry.
  - `inst_data` is forced to 16'h0000 when empty.
  - `inst_valid` = (`level` != 0).
- **Pointers.** Wrap modulo `FIFO_DEPTH`. `level` saturates naturally at `FIFO_DEPTH` (full) and 0 (empty).
- **Flush.**
  - Takes priority over everything.
  - At the next edge, `level`=0, `hi_valid`=0 and the counter is 0.
  - A byte handshaking in the flush cycle is discarded.
  - An instruction handshaking in the flush cycle counts as consumed.
  - No `timeout_drop` pulse.
- **Reset.**
  - Same effect as flush.
  - Output values after reset: `byte_ready`=1, `inst_valid`=0, `inst_data`=16'h0000, `level`=0, `timeout_drop`=0.
  - A reset mid-instruction loses the pending high byte silently.

## Timing
- **Latency.** Low byte accepted at edge t → `inst_valid`=1 and `inst_data` valid immediately after edge t (1 cycle from handshake).
- **Throughput.** One byte per cycle in; one instruction per cycle out.
- **`timeout_drop` timing.** Asserted for exactly the cycle after the discarding edge.
- **Input-to-output paths.** None are combinational: `byte_ready` and `inst_valid` never depend on `inst_ready`, `byte_valid` or `flush` in the same cycle.

## Structure
- **Shared package `isa_pkg`.**
  - `INST_W`=16, `BYTE_W`=8.
  - Field slices [Op 15:14][Mod 13:8][Src 7:4][Dst 3:0].
  - Shared with the executor's decode.
- **Sub-module `sync_fifo`.** Generic FWFT, width/depth parameters, with ports `wr_en`, `rd_en`, `clr`, `full`, `empty`, `level`. It holds the storage and pointers; the framer owns pairing and timeout.
- **Target size.** About 150–250 lines total.

## Test plan
- **Pairing.** Bytes 0x41, 0x23 with idle gaps, then 0x00, 0x53 → two instructions in order: 0x4123, 0x0053. `level` goes 1, 2, then 1, 0 as `inst_ready` pulses.
- **Full.** Hold `inst_ready`=0 and send 10 bytes (`FIFO_DEPTH`=4).
  - After 8 bytes, `level`=4.
  - The 9th byte is accepted as high; `byte_ready`=0 for the 10th.
  - One pop → 10th byte accepted → `level` returns to 4.
  - Entries are intact, in FIFO order.
- **Timeout** (`TIMEOUT_CYCLES`=16).
  - Send 0xAA, wait → `timeout_drop` pulses once, 16 cycles after acceptance.
  - Then 0x12, 0x34 → 0x1234, proving realignment.
  - Variant: low byte arrives exactly on the 16th cycle → 0xAAxx output with no pulse.
- **Timer pause.** FIFO full plus a pending high byte with 40 stall cycles → no `timeout_drop`. After a pop, the low byte completes the instruction.
- **Concurrency.** At `level`=2, do a write and a pop in the same cycle → `level` stays 2 and the head advances.
- **Flush and reset.**
  - `flush` while `level`=3 with a high byte pending → next cycle `level`=0, `inst_valid`=0, `inst_data`=0. The next two bytes form a fresh instruction.
  - `rst` mid-instruction gives the identical result.
